// File: rtl/gpu_cmd_raster_writer.sv
// Command FIFO + decoder that turns draw commands into framebuffer pixel writes on an Avalon-style master.
// Optional build macro GPU_CLIP_EN: skip pixels outside FB_WIDTH x FB_HEIGHT instead of wrapping the address.
module gpu_cmd_raster_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 32,
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       fifo_write_data,
  input  logic              fifo_write,
  output logic              fifo_full,
  input  logic              SD_waitrequest,
  output logic              SD_write,
  output logic [DATA_W-1:0] SD_wdata,
  output logic [ADDR_W-1:0] SD_address,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        drop_count
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int COL_W  = (DATA_W < 28) ? DATA_W : 28;
  localparam int WIDE_W = ADDR_W + 12;
  localparam logic [12:0]      FB_W_X  = 13'(FB_WIDTH);
  localparam logic [11:0]      FB_H_Y  = 12'(FB_HEIGHT);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [3:0] OP_POINT = 4'h0;
  localparam logic [3:0] OP_COLOR = 4'h1;
  localparam logic [3:0] OP_END   = 4'h2;
  localparam logic [3:0] OP_SPAN  = 4'h3;

`ifdef GPU_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [12:0] x, input logic [11:0] y);
    logic [WIDE_W-1:0] wide;
    wide = WIDE_W'(BASE_ADDR) + WIDE_W'(y) * WIDE_W'(FB_WIDTH) + WIDE_W'(x);
    return wide[ADDR_W-1:0];
  endfunction

  state_t              state_r, state_nx_s;
  logic [31:0]         mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [31:0]         cmd_r;
  logic [DATA_W-1:0]   colour_r, sd_wdata_r;
  logic [ADDR_W-1:0]   sd_address_r;
  logic [11:0]         cur_x_r, cur_y_r, remain_r;
  logic [12:0]         beat_x_r;
  logic [7:0]          drop_cnt_r;
  logic                sd_write_r, frame_done_r;

  logic                full_s, pop_s, push_s, drop_s, beat_done_s, last_beat_s;
  logic                point_in_s, span_in_s;
  logic [3:0]          op_s;
  logic [11:0]         fa_s, fb_y_s;
  logic [12:0]         span_x0_s, next_x_s;

  // A push into a full FIFO still lands when the FSM pops in the same cycle.
  assign full_s      = (cnt_r == DEPTH_C);
  assign pop_s       = (state_r == IDLE) && (cnt_r != CNT_W'(0));
  assign push_s      = fifo_write && (!full_s || pop_s);
  assign drop_s      = fifo_write && full_s && !pop_s;

  assign op_s        = cmd_r[31:28];
  assign fa_s        = cmd_r[27:16];
  assign fb_y_s      = cmd_r[11:0];
  assign span_x0_s   = {1'b0, cur_x_r} + 13'd1;
  assign next_x_s    = beat_x_r + 13'd1;
  assign point_in_s  = ({1'b0, fa_s} < FB_W_X) && (fb_y_s < FB_H_Y);
  assign span_in_s   = (span_x0_s < FB_W_X) && (cur_y_r < FB_H_Y);
  assign beat_done_s = (state_r == WRITE) && !SD_waitrequest;
  assign last_beat_s = (remain_r == 12'd1) || (CLIP_EN && (next_x_s >= FB_W_X));

  assign fifo_full   = full_s;
  assign busy        = (cnt_r != CNT_W'(0)) || (state_r != IDLE);
  assign SD_write    = sd_write_r;
  assign SD_wdata    = sd_wdata_r;
  assign SD_address  = sd_address_r;
  assign frame_done  = frame_done_r;
  assign drop_count  = drop_cnt_r;

  // FIFO storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= fifo_write_data;
    end
  end

  // FIFO pointers, occupancy, overflow counter and command register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= PTR_W'(0);
      rd_ptr_r   <= PTR_W'(0);
      cnt_r      <= CNT_W'(0);
      cmd_r      <= 32'h0;
      drop_cnt_r <= 8'h00;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        cmd_r    <= mem_r[rd_ptr_r];
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
      if (drop_s && (drop_cnt_r != 8'hFF)) drop_cnt_r <= drop_cnt_r + 8'h01;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (pop_s) state_nx_s = EXEC;
        else       state_nx_s = IDLE;
      end
      EXEC: begin
        case (op_s)
          OP_POINT: begin
            if (!CLIP_EN || point_in_s) state_nx_s = WRITE;
            else                        state_nx_s = IDLE;
          end
          OP_SPAN: begin
            if ((fa_s != 12'd0) && (!CLIP_EN || span_in_s)) state_nx_s = WRITE;
            else                                            state_nx_s = IDLE;
          end
          default: state_nx_s = IDLE;
        endcase
      end
      WRITE: begin
        if (beat_done_s && last_beat_s) state_nx_s = IDLE;
        else                            state_nx_s = WRITE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Command execution, cursor/colour state and the registered write-master outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sd_write_r   <= 1'b0;
      sd_wdata_r   <= DATA_W'(0);
      sd_address_r <= ADDR_W'(0);
      frame_done_r <= 1'b0;
      colour_r     <= DATA_W'(0);
      cur_x_r      <= 12'd0;
      cur_y_r      <= 12'd0;
      beat_x_r     <= 13'd0;
      remain_r     <= 12'd0;
    end else begin
      sd_write_r   <= (state_nx_s == WRITE);
      frame_done_r <= (state_r == EXEC) && (op_s == OP_END);
      case (state_r)
        EXEC: begin
          case (op_s)
            OP_POINT: begin
              cur_x_r      <= fa_s;
              cur_y_r      <= fb_y_s;
              beat_x_r     <= {1'b0, fa_s};
              remain_r     <= 12'd1;
              sd_address_r <= pix_addr({1'b0, fa_s}, fb_y_s);
              sd_wdata_r   <= colour_r;
            end
            OP_COLOR: colour_r <= DATA_W'(cmd_r[COL_W-1:0]);
            OP_SPAN: begin
              beat_x_r     <= span_x0_s;
              remain_r     <= fa_s;
              sd_address_r <= pix_addr(span_x0_s, cur_y_r);
              sd_wdata_r   <= colour_r;
            end
            default: colour_r <= colour_r;
          endcase
        end
        WRITE: begin
          // Address/data only move once the slave has taken the current beat.
          if (beat_done_s) begin
            cur_x_r <= beat_x_r[11:0];
            if (!last_beat_s) begin
              beat_x_r     <= next_x_s;
              remain_r     <= remain_r - 12'd1;
              sd_address_r <= pix_addr(next_x_s, cur_y_r);
              sd_wdata_r   <= colour_r;
            end
          end
        end
        default: remain_r <= remain_r;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_cmd_raster_writer.sv
// Directed self-checking bench for gpu_cmd_raster_writer (default parameters).
module tb_gpu_cmd_raster_writer;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       fifo_write_data;
  logic              fifo_write;
  logic              fifo_full;
  logic              SD_waitrequest;
  logic              SD_write;
  logic [DATA_W-1:0] SD_wdata;
  logic [ADDR_W-1:0] SD_address;
  logic              busy;
  logic              frame_done;
  logic [7:0]        drop_count;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] addr_q[$];
  logic [DATA_W-1:0] data_q[$];

  gpu_cmd_raster_writer dut (
    .clk             (clk),
    .reset           (reset),
    .fifo_write_data (fifo_write_data),
    .fifo_write      (fifo_write),
    .fifo_full       (fifo_full),
    .SD_waitrequest  (SD_waitrequest),
    .SD_write        (SD_write),
    .SD_wdata        (SD_wdata),
    .SD_address      (SD_address),
    .busy            (busy),
    .frame_done      (frame_done),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  // Log every accepted beat.
  always @(posedge clk) begin
    if (reset && SD_write && !SD_waitrequest) begin
      addr_q.push_back(SD_address);
      data_q.push_back(SD_wdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    fifo_write_data = w;
    fifo_write      = 1'b1;
    step();
    fifo_write      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    fifo_write = 1'b0;
    fifo_write_data = 32'h0;
    SD_waitrequest = 1'b0;
    repeat (3) step();
    checks++;
    if ({SD_write, frame_done, busy, fifo_full} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {SD_write, frame_done, busy, fifo_full});
    end
    checks++;
    if (SD_address !== 22'd0 || SD_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus: got addr %0d data %0h expected 0/0", SD_address, SD_wdata);
    end
    checks++;
    if (drop_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_drop: got %0d expected 0", drop_count);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_point_latency();
    int base;
    push(32'h10000002);
    repeat (3) step();
    base = addr_q.size();
    push(32'h001E0064);
    checks++;
    if (SD_write !== 1'b0) begin
      errors++;
      $display("FAIL lat_edge1: got SD_write %b expected 0", SD_write);
    end
    step();
    checks++;
    if (SD_write !== 1'b0) begin
      errors++;
      $display("FAIL lat_edge2: got SD_write %b expected 0", SD_write);
    end
    step();
    checks++;
    if (SD_write !== 1'b1 || SD_address !== 22'd64030 || SD_wdata !== 32'h2) begin
      errors++;
      $display("FAIL point_write: got wr %b addr %0d data %0h expected 1 64030 2", SD_write, SD_address, SD_wdata);
    end
    step();
    checks++;
    if (SD_write !== 1'b0 || addr_q.size() - base !== 1) begin
      errors++;
      $display("FAIL point_count: got wr %b beats %0d expected 0 1", SD_write, addr_q.size() - base);
    end
  endtask

  task automatic test_span_stall();
    int base;
    int n;
    logic [ADDR_W-1:0] exp_a [3];
    exp_a[0] = 22'd12811;
    exp_a[1] = 22'd12812;
    exp_a[2] = 22'd12813;
    push(32'h000A0014);
    repeat (5) step();
    base = addr_q.size();
    push(32'h30030000);
    n = 0;
    while (SD_write !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (SD_write !== 1'b1) begin
      errors++;
      $display("FAIL span_start: got SD_write %b expected 1 within 10 cycles", SD_write);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (SD_write !== 1'b1 || SD_address !== exp_a[i]) begin
        errors++;
        $display("FAIL span_beat%0d: got wr %b addr %0d expected 1 %0d", i, SD_write, SD_address, exp_a[i]);
      end
      SD_waitrequest = 1'b1;
      step();
      checks++;
      if (SD_write !== 1'b1 || SD_address !== exp_a[i]) begin
        errors++;
        $display("FAIL span_stall%0d_a: got wr %b addr %0d expected 1 %0d", i, SD_write, SD_address, exp_a[i]);
      end
      step();
      checks++;
      if (SD_write !== 1'b1 || SD_address !== exp_a[i]) begin
        errors++;
        $display("FAIL span_stall%0d_b: got wr %b addr %0d expected 1 %0d", i, SD_write, SD_address, exp_a[i]);
      end
      SD_waitrequest = 1'b0;
      step();
    end
    checks++;
    if (SD_write !== 1'b0 || addr_q.size() - base !== 3) begin
      errors++;
      $display("FAIL span_count: got wr %b beats %0d expected 0 3", SD_write, addr_q.size() - base);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (addr_q.size() > base + i && addr_q[base + i] !== exp_a[i]) begin
        errors++;
        $display("FAIL span_order%0d: got %0d expected %0d", i, addr_q[base + i], exp_a[i]);
      end
    end
  endtask

  task automatic test_end();
    int base;
    int hits;
    int first;
    logic busy_next;
    base = addr_q.size();
    hits = 0;
    first = -1;
    busy_next = 1'bx;
    push(32'h20000000);
    for (int c = 0; c < 8; c++) begin
      if (frame_done === 1'b1) begin
        hits++;
        if (first < 0) first = c;
      end
      if (first >= 0 && c == first + 1) busy_next = busy;
      step();
    end
    checks++;
    if (hits !== 1) begin
      errors++;
      $display("FAIL end_pulse: got %0d cycles high expected 1", hits);
    end
    checks++;
    if (busy_next !== 1'b0) begin
      errors++;
      $display("FAIL end_busy: got %b expected 0", busy_next);
    end
    checks++;
    if (addr_q.size() - base !== 0) begin
      errors++;
      $display("FAIL end_nowrite: got %0d beats expected 0", addr_q.size() - base);
    end
  endtask

  task automatic test_fifo_full();
    int base;
    int n;
    base = addr_q.size();
    SD_waitrequest = 1'b1;
    push(32'h00050005);
    n = 0;
    while (SD_write !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    for (int i = 0; i < 8; i++) push(32'hF0000000);
    checks++;
    if (fifo_full !== 1'b1 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL fill8: got full %b drop %0d expected 1 0", fifo_full, drop_count);
    end
    for (int i = 0; i < 3; i++) push(32'hF0000000);
    checks++;
    if (fifo_full !== 1'b1 || drop_count !== 8'd3) begin
      errors++;
      $display("FAIL overflow: got full %b drop %0d expected 1 3", fifo_full, drop_count);
    end
    SD_waitrequest = 1'b0;
    step();
    push(32'h00010001);
    checks++;
    if (fifo_full !== 1'b1 || drop_count !== 8'd3) begin
      errors++;
      $display("FAIL push_pop_full: got full %b drop %0d expected 1 3", fifo_full, drop_count);
    end
    n = 0;
    while (busy !== 1'b0 && n < 80) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain: got busy %b expected 0 within 80 cycles", busy);
    end
    checks++;
    if (addr_q.size() - base !== 2 || addr_q[addr_q.size() - 1] !== 22'd641) begin
      errors++;
      $display("FAIL drain_writes: got %0d beats last %0d expected 2 641", addr_q.size() - base, addr_q[addr_q.size() - 1]);
    end
  endtask

  task automatic test_clip();
    int base;
    int n;
    logic [ADDR_W-1:0] exp_q[$];
`ifdef GPU_CLIP_EN
    exp_q = '{22'd637, 22'd638, 22'd639};
`else
    exp_q = '{22'd3900, 22'd637, 22'd638, 22'd639, 22'd640, 22'd641, 22'd642};
`endif
    SD_waitrequest = 1'b0;
    base = addr_q.size();
    push(32'h02BC0005);
    repeat (5) step();
    push(32'h027D0000);
    repeat (5) step();
    push(32'h30050000);
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (addr_q.size() - base !== exp_q.size()) begin
      errors++;
      $display("FAIL clip_count: got %0d beats expected %0d", addr_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (addr_q.size() <= base + i || addr_q[base + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL clip_addr%0d: got %0d expected %0d", i,
                 (addr_q.size() > base + i) ? addr_q[base + i] : 22'h3FFFFF, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int base;
    int n;
    SD_waitrequest = 1'b1;
    push(32'h00070003);
    n = 0;
    while (SD_write !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    for (int i = 0; i < 3; i++) push(32'hF0000000);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (SD_write !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got SD_write %b expected 0", SD_write);
    end
    step();
    step();
    reset = 1'b1;
    SD_waitrequest = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || fifo_full !== 1'b0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL post_reset: got busy %b full %b drop %0d expected 0 0 0", busy, fifo_full, drop_count);
    end
    base = addr_q.size();
    push(32'h30010000);
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (addr_q.size() - base !== 1 || addr_q[addr_q.size() - 1] !== 22'd1 || data_q[data_q.size() - 1] !== 32'd0) begin
      errors++;
      $display("FAIL reset_cursor_colour: got %0d beats addr %0d data %0h expected 1 1 0",
               addr_q.size() - base, addr_q[addr_q.size() - 1], data_q[data_q.size() - 1]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_point_latency();
    test_span_stall();
    test_end();
    test_fifo_full();
    test_clip();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
